divider_ieee_754_verilog: RTL and testbench
===========================================

Name: divider_ieee_754_verilog

Overview:
Sequential IEEE-754 single-precision floating-point divider, res = op1 / op2. It is the inverse-operation companion to the team's FP32 multiplier and uses the same in_rdy/res_rdy handshake, so both sit side by side in the FP datapath. The mantissa quotient comes from an iterative restoring divider that produces one bit per cycle, followed by round-to-nearest-even. Denormal inputs and underflowing results are flushed to zero.

Parameters:
SIZE_OF_MANTISSA, 23, stored fraction width (fixed for FP32; not intended to be overridden)
SIZE_OF_EXPONENT, 8, exponent field width
BIAS, 127, exponent bias

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
op1  in  32  dividend, sampled only at the accept edge
op2  in  32  divisor, sampled only at the accept edge
in_rdy  in  1  request; operands accepted when in_rdy=1 and busy=0
res  out  32  result; holds its value until the next result is written
res_rdy  out  1  one-cycle pulse marking res valid
busy  out  1  high from the accept edge until the cycle after res_rdy

Behaviour:
- Reset (rst=0, async): state=IDLE; res=0, res_rdy=0, busy=0; all internal registers cleared. If reset arrives mid-operation, that operation is aborted and produces no res_rdy.
- States: IDLE, CLASSIFY, ALIGN, DIVIDE, ROUND, OUT.
- IDLE: when in_rdy=1, edge E0 captures op1/op2 and s = op1[31]^op2[31], sets busy=1, and moves to CLASSIFY. in_rdy is ignored while busy=1 (no queuing).
- CLASSIFY (edge E1): any exponent field of 0 is treated as zero, whatever the fraction. Priority order:
  - either operand NaN (exp=FF, frac!=0) -> 0x7FC00000
  - 0/0 or inf/inf -> 0x7FC00000
  - inf/finite -> {s,FF,0}
  - finite nonzero/0 -> {s,FF,0}
  - finite/inf -> {s,00,0}
  - 0/finite -> {s,00,0}
  - otherwise -> ALIGN
  - Special cases go to OUT with the result latched.
- ALIGN (E2): ma={1,frac1}, mb={1,frac2}, e = ea - eb + BIAS as 10-bit signed. If ma<mb: ma<<=1 and e-=1. Remainder r = ma (25 bits), quotient q=0, counter=0.
- DIVIDE (E3..E27, exactly 25 cycles), each cycle:
  - if r>=mb: q={q,1}, r=(r-mb)<<1
  - else: q={q,0}, r=r<<1
  - counter increments; leave DIVIDE when counter=24.
- ROUND (E28):
  - mant=q[24:1], guard=q[0], sticky=(r!=0)
  - increment mant if guard && (sticky || mant[0])
  - carry out to 2^24 -> mant=0x800000, e+=1
- OUT (E29 normal, E2 special):
  - normal-path range check first: e>=255 -> {s,FF,0}; e<=0 -> {s,00,0}; else {s,e[7:0],mant[22:0]}
  - res is written and res_rdy=1 for this one cycle
  - next edge: res_rdy=0, busy=0, state=IDLE
  - a new in_rdy can be accepted on the edge after res_rdy drops
- Latency from the accept edge to the edge raising res_rdy: 29 cycles on the normal path, 2 on special cases. The earliest back-to-back accept is 31 edges after the previous one.
- Widths: e is 10-bit signed (range -127..380, no wrap). r is 25 bits, and r-mb never underflows when selected.

Decomposition:
- Shared package/include (common with the multiplier):
  - constants QNAN=0x7FC00000, EXP_MAX=8'hFF, BIAS
  - field-slice macros
  - state encodings
- One natural sub-module: fp32_classify (combinational; outputs is_nan/is_inf/is_zero per operand). It is reusable by the multiplier.
- The division iteration stays inline in the FSM.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> res=0x40400000, res_rdy pulse exactly 29 cycles after accept, one cycle wide, busy low the following cycle.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (ALIGN shift plus round-up); 0xBF800000 / 0x3F800000 -> 0xBF800000.
- Specials, each with a 2-cycle latency:
  - 0x3F800000/0 -> 0x7F800000
  - 0xBF800000/0 -> 0xFF800000
  - 0/0 -> 0x7FC00000
  - 0x7F800000/0x7F800000 -> 0x7FC00000
  - 0x7FC00001/x -> 0x7FC00000
  - 0x40000000/0x7F800000 -> 0x00000000
- Range edges:
  - 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 (overflow)
  - 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush)
  - 0x00400000 (denormal) / 0x3F800000 -> 0x00000000
- Handshake: hold in_rdy=1 continuously with changing operands -> only the value present at each accept edge is used; mid-operation changes are ignored; one res_rdy per accept.
- Reset: drive rst=0 for 1 cycle during DIVIDE (cycle 10) -> res=0, res_rdy=0, busy=0 immediately and no res_rdy follows; next request 6/2 -> 0x40400000.

Source files
------------

// File: rtl/divider_ieee_754_verilog_pkg.sv
// Shared FP32 definitions for the divider (and the companion multiplier):
// special constants, field slices and the sequencer state encoding.
package divider_ieee_754_verilog_pkg;

    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam int          FP32_BIAS = 127;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLASSIFY = 3'd1,
        ST_ALIGN    = 3'd2,
        ST_DIVIDE   = 3'd3,
        ST_ROUND    = 3'd4,
        ST_OUT      = 3'd5
    } state_t;

    // Field slices operate on the 31-bit magnitude (sign removed).
    function automatic logic [7:0] fp_exp(input logic [30:0] mag);
        return mag[30:23];
    endfunction

    function automatic logic [22:0] fp_frac(input logic [30:0] mag);
        return mag[22:0];
    endfunction

    function automatic logic fp_sign(input logic [31:0] value);
        return value[31];
    endfunction

endpackage

// File: rtl/divider_ieee_754_verilog_fp32_classify.sv
// Combinational FP32 operand classifier. Denormals (exponent 0) are
// reported as zero because the datapath flushes them.
module fp32_classify
    import divider_ieee_754_verilog_pkg::*;
(
    input  logic [30:0] i_mag,
    output logic        o_is_nan,
    output logic        o_is_inf,
    output logic        o_is_zero
);

    logic [7:0]  w_exp;
    logic [22:0] w_frac;

    assign w_exp  = fp_exp(i_mag);
    assign w_frac = fp_frac(i_mag);

    // Decode the exponent/fraction combination into the three classes.
    always_comb begin
        o_is_nan  = (w_exp == EXP_MAX) && (w_frac != 23'd0);
        o_is_inf  = (w_exp == EXP_MAX) && (w_frac == 23'd0);
        o_is_zero = (w_exp == 8'd0);
    end

endmodule

// File: rtl/divider_ieee_754_verilog.sv
// Sequential FP32 divider: res = op1 / op2. Restoring mantissa division
// producing one quotient bit per cycle, round-to-nearest-even, and
// flush-to-zero for denormal inputs and underflowing results.
module divider_ieee_754_verilog
    import divider_ieee_754_verilog_pkg::*;
#(
    parameter int SIZE_OF_MANTISSA = 23,
    parameter int SIZE_OF_EXPONENT = 8,
    parameter int BIAS             = FP32_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        in_rdy,
    output logic [31:0] res,
    output logic        res_rdy,
    output logic        busy
);

    localparam int         MW        = SIZE_OF_MANTISSA + 1;  // mantissa incl. hidden bit
    localparam int         RW        = MW + 1;                // remainder width
    localparam logic [4:0] LAST_STEP = 5'(RW - 1);            // one quotient bit per step

    state_t r_state;
    state_t w_state_next;

    logic [30:0]                   r_mag1;
    logic [30:0]                   r_mag2;
    logic                          r_sign;
    logic                          r_special;
    logic [31:0]                   r_special_res;
    logic signed [9:0]             r_e;
    logic [MW-1:0]                 r_mb;
    logic [RW-1:0]                 r_r;
    // The quotient always starts with a 1 (ma >= mb after alignment), so only
    // the 24 bits below that leading one are kept: fraction[22:0] + guard.
    logic [MW-1:0]                 r_q;
    logic [4:0]                    r_cnt;
    logic [SIZE_OF_MANTISSA-1:0]   r_frac;

    logic                          w_nan1, w_inf1, w_zero1;
    logic                          w_nan2, w_inf2, w_zero2;
    logic                          w_special;
    logic [31:0]                   w_special_res;
    logic [SIZE_OF_EXPONENT-1:0]   w_ea, w_eb;
    logic [MW-1:0]                 w_ma, w_mb;
    logic                          w_shift;
    logic [9:0]                    w_e_raw;
    logic [9:0]                    w_e_align;
    logic                          w_ge;
    logic [RW-1:0]                 w_rem;
    logic                          w_inc;
    logic [MW-1:0]                 w_frac_sum;
    logic                          w_carry;

    fp32_classify u_class_op1 (
        .i_mag     (r_mag1),
        .o_is_nan  (w_nan1),
        .o_is_inf  (w_inf1),
        .o_is_zero (w_zero1)
    );

    fp32_classify u_class_op2 (
        .i_mag     (r_mag2),
        .o_is_nan  (w_nan2),
        .o_is_inf  (w_inf2),
        .o_is_zero (w_zero2)
    );

    // Special-case resolution in priority order; anything else is a normal divide.
    always_comb begin
        w_special     = 1'b1;
        w_special_res = 32'd0;
        if (w_nan1 || w_nan2) begin
            w_special_res = QNAN;
        end else if ((w_zero1 && w_zero2) || (w_inf1 && w_inf2)) begin
            w_special_res = QNAN;
        end else if (w_inf1 || w_zero2) begin
            w_special_res = {r_sign, EXP_MAX, 23'd0};
        end else if (w_inf2 || w_zero1) begin
            w_special_res = {r_sign, 8'd0, 23'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    // Alignment: biased exponent difference, pre-shift dividend so q >= 1.
    assign w_ea      = fp_exp(r_mag1);
    assign w_eb      = fp_exp(r_mag2);
    assign w_ma      = {1'b1, fp_frac(r_mag1)};
    assign w_mb      = {1'b1, fp_frac(r_mag2)};
    assign w_shift   = (w_ma < w_mb);
    assign w_e_raw   = {2'b00, w_ea} - {2'b00, w_eb} + 10'(BIAS);
    assign w_e_align = w_e_raw - {9'd0, w_shift};

    // One restoring-division step; the remainder never exceeds 2*mb so it fits RW bits.
    assign w_ge  = (r_r >= {1'b0, r_mb});
    assign w_rem = w_ge ? (r_r - {1'b0, r_mb}) : r_r;

    // Round to nearest even: guard is the last quotient bit, sticky is the remainder.
    assign w_inc      = r_q[0] && ((r_r != '0) || r_q[1]);
    assign w_frac_sum = {1'b0, r_q[MW-1:1]} + MW'(w_inc);
    assign w_carry    = w_frac_sum[MW-1];

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; OUT lasts two edges: write result, then release.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (in_rdy) w_state_next = ST_CLASSIFY;
            ST_CLASSIFY: w_state_next = w_special ? ST_OUT : ST_ALIGN;
            ST_ALIGN:    w_state_next = ST_DIVIDE;
            ST_DIVIDE:   if (r_cnt == LAST_STEP) w_state_next = ST_ROUND;
            ST_ROUND:    w_state_next = ST_OUT;
            ST_OUT:      if (res_rdy) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Datapath registers and handshake outputs, updated per state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mag1        <= '0;
            r_mag2        <= '0;
            r_sign        <= 1'b0;
            r_special     <= 1'b0;
            r_special_res <= '0;
            r_e           <= '0;
            r_mb          <= '0;
            r_r           <= '0;
            r_q           <= '0;
            r_cnt         <= '0;
            r_frac        <= '0;
            res           <= '0;
            res_rdy       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_rdy) begin
                        r_mag1    <= op1[30:0];
                        r_mag2    <= op2[30:0];
                        r_sign    <= fp_sign(op1) ^ fp_sign(op2);
                        r_special <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_CLASSIFY: begin
                    r_special     <= w_special;
                    r_special_res <= w_special_res;
                end
                ST_ALIGN: begin
                    r_e   <= $signed(w_e_align);
                    r_mb  <= w_mb;
                    r_r   <= w_shift ? {w_ma, 1'b0} : {1'b0, w_ma};
                    r_q   <= '0;
                    r_cnt <= '0;
                end
                ST_DIVIDE: begin
                    r_q   <= {r_q[MW-2:0], w_ge};
                    r_r   <= w_rem << 1;
                    r_cnt <= r_cnt + 5'd1;
                end
                ST_ROUND: begin
                    r_frac <= w_carry ? '0 : w_frac_sum[SIZE_OF_MANTISSA-1:0];
                    r_e    <= r_e + $signed({9'd0, w_carry});
                end
                ST_OUT: begin
                    if (!res_rdy) begin
                        res_rdy <= 1'b1;
                        if (r_special) begin
                            res <= r_special_res;
                        end else if (r_e >= 10'sd255) begin
                            res <= {r_sign, EXP_MAX, 23'd0};
                        end else if (r_e <= 10'sd0) begin
                            res <= {r_sign, 8'd0, 23'd0};
                        end else begin
                            res <= {r_sign, r_e[7:0], r_frac};
                        end
                    end else begin
                        res_rdy <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_ieee_754_verilog.sv
// Directed bench for the FP32 divider: normal quotients, specials, range
// edges, handshake behaviour with in_rdy held high, and mid-operation reset.
module tb_divider_ieee_754_verilog;

    logic        clk;
    logic        rst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        in_rdy;
    logic [31:0] res;
    logic        res_rdy;
    logic        busy;

    int errors = 0;
    int checks = 0;

    divider_ieee_754_verilog dut (
        .clk     (clk),
        .rst     (rst),
        .op1     (op1),
        .op2     (op2),
        .in_rdy  (in_rdy),
        .res     (res),
        .res_rdy (res_rdy),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for its result.
    // lat = edges from the accept edge to the edge raising res_rdy, 0 on timeout.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat,
                         output logic rdy_after, output logic busy_after);
        @(negedge clk);
        op1    = a;
        op2    = b;
        in_rdy = 1'b1;
        @(posedge clk);
        #1;
        in_rdy = 1'b0;
        lat = 0;
        r   = 32'hDEAD_BEEF;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (res_rdy) begin
                lat = n;
                r   = res;
                break;
            end
        end
        @(posedge clk);
        #1;
        rdy_after  = res_rdy;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        in_rdy = 1'b0;
        op1    = 32'd0;
        op2    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (res !== 32'd0) begin
            errors++;
            $display("FAIL reset_res: got %h expected %h", res, 32'd0);
        end
        checks++;
        if (res_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_res_rdy: got %b expected 0", res_rdy);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        $display("reset: res=%h res_rdy=%b busy=%b", res, res_rdy, busy);
    endtask

    task automatic test_normal();
        logic [31:0] a_tab [3] = '{32'h40C0_0000, 32'h3F80_0000, 32'hBF80_0000};
        logic [31:0] b_tab [3] = '{32'h4000_0000, 32'h4040_0000, 32'h3F80_0000};
        logic [31:0] e_tab [3] = '{32'h4040_0000, 32'h3EAA_AAAB, 32'hBF80_0000};
        logic [31:0] r;
        int          lat;
        logic        rdy_after, busy_after;
        for (int i = 0; i < 3; i++) begin
            do_op(a_tab[i], b_tab[i], r, lat, rdy_after, busy_after);
            $display("normal: %h / %h -> %h latency=%0d", a_tab[i], b_tab[i], r, lat);
            checks++;
            if (r !== e_tab[i]) begin
                errors++;
                $display("FAIL normal_res[%0d]: got %h expected %h", i, r, e_tab[i]);
            end
            checks++;
            if (lat != 29) begin
                errors++;
                $display("FAIL normal_latency[%0d]: got %0d expected 29", i, lat);
            end
            checks++;
            if (rdy_after !== 1'b0) begin
                errors++;
                $display("FAIL normal_pulse_width[%0d]: got %b expected 0", i, rdy_after);
            end
            checks++;
            if (busy_after !== 1'b0) begin
                errors++;
                $display("FAIL normal_busy_drop[%0d]: got %b expected 0", i, busy_after);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] a_tab [6] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000,
                                   32'h7F80_0000, 32'h7FC0_0001, 32'h4000_0000};
        logic [31:0] b_tab [6] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                                   32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000};
        logic [31:0] e_tab [6] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                                   32'h7FC0_0000, 32'h7FC0_0000, 32'h0000_0000};
        logic [31:0] r;
        int          lat;
        logic        rdy_after, busy_after;
        for (int i = 0; i < 6; i++) begin
            do_op(a_tab[i], b_tab[i], r, lat, rdy_after, busy_after);
            $display("special: %h / %h -> %h latency=%0d", a_tab[i], b_tab[i], r, lat);
            checks++;
            if (r !== e_tab[i]) begin
                errors++;
                $display("FAIL special_res[%0d]: got %h expected %h", i, r, e_tab[i]);
            end
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL special_latency[%0d]: got %0d expected 2", i, lat);
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] a_tab [3] = '{32'h7F7F_FFFF, 32'h0080_0000, 32'h0040_0000};
        logic [31:0] b_tab [3] = '{32'h3F00_0000, 32'h4000_0000, 32'h3F80_0000};
        logic [31:0] e_tab [3] = '{32'h7F80_0000, 32'h0000_0000, 32'h0000_0000};
        int          l_tab [3] = '{29, 29, 2};
        logic [31:0] r;
        int          lat;
        logic        rdy_after, busy_after;
        for (int i = 0; i < 3; i++) begin
            do_op(a_tab[i], b_tab[i], r, lat, rdy_after, busy_after);
            $display("range: %h / %h -> %h latency=%0d", a_tab[i], b_tab[i], r, lat);
            checks++;
            if (r !== e_tab[i]) begin
                errors++;
                $display("FAIL range_res[%0d]: got %h expected %h", i, r, e_tab[i]);
            end
            checks++;
            if (lat != l_tab[i]) begin
                errors++;
                $display("FAIL range_latency[%0d]: got %0d expected %0d", i, lat, l_tab[i]);
            end
        end
    endtask

    // in_rdy held high: the first accept sees 6/2, operands then switch to 1/3,
    // which is what the second accept (31 edges later) must pick up.
    task automatic test_back_to_back();
        int          pulses = 0;
        logic [31:0] res_seen [2] = '{32'd0, 32'd0};
        int          edge_seen [2] = '{0, 0};
        logic        busy_at_31 = 1'b0;
        @(negedge clk);
        op1    = 32'h40C0_0000;
        op2    = 32'h4000_0000;
        in_rdy = 1'b1;
        @(posedge clk);
        #1;
        op1 = 32'h3F80_0000;
        op2 = 32'h4040_0000;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk);
            #1;
            if (res_rdy) begin
                if (pulses < 2) begin
                    res_seen[pulses]  = res;
                    edge_seen[pulses] = n;
                end
                pulses++;
            end
            if (n == 31) begin
                busy_at_31 = busy;
                op1    = 32'hBF80_0000;
                op2    = 32'h3F80_0000;
                in_rdy = 1'b0;
            end
        end
        $display("back_to_back: pulses=%0d res0=%h@%0d res1=%h@%0d", pulses,
                 res_seen[0], edge_seen[0], res_seen[1], edge_seen[1]);
        checks++;
        if (busy_at_31 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reaccept: busy got %b expected 1", busy_at_31);
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d expected 2", pulses);
        end
        checks++;
        if (res_seen[0] !== 32'h4040_0000) begin
            errors++;
            $display("FAIL b2b_res0: got %h expected %h", res_seen[0], 32'h4040_0000);
        end
        checks++;
        if (edge_seen[0] != 29) begin
            errors++;
            $display("FAIL b2b_edge0: got %0d expected 29", edge_seen[0]);
        end
        checks++;
        if (res_seen[1] !== 32'h3EAA_AAAB) begin
            errors++;
            $display("FAIL b2b_res1: got %h expected %h", res_seen[1], 32'h3EAA_AAAB);
        end
        checks++;
        if (edge_seen[1] != 60) begin
            errors++;
            $display("FAIL b2b_edge1: got %0d expected 60", edge_seen[1]);
        end
    endtask

    task automatic test_reset_mid_divide();
        int          pulses = 0;
        logic [31:0] r;
        int          lat;
        logic        rdy_after, busy_after;
        @(negedge clk);
        op1    = 32'h40C0_0000;
        op2    = 32'h4000_0000;
        in_rdy = 1'b1;
        @(posedge clk);
        #1;
        in_rdy = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        $display("reset_mid: res=%h res_rdy=%b busy=%b", res, res_rdy, busy);
        checks++;
        if (res !== 32'd0) begin
            errors++;
            $display("FAIL midreset_res: got %h expected %h", res, 32'd0);
        end
        checks++;
        if (res_rdy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_res_rdy: got %b expected 0", res_rdy);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy: got %b expected 0", busy);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (res_rdy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_no_result: got %0d pulses expected 0", pulses);
        end
        do_op(32'h40C0_0000, 32'h4000_0000, r, lat, rdy_after, busy_after);
        $display("after_reset: 40c00000 / 40000000 -> %h latency=%0d", r, lat);
        checks++;
        if (r !== 32'h4040_0000) begin
            errors++;
            $display("FAIL midreset_next_res: got %h expected %h", r, 32'h4040_0000);
        end
        checks++;
        if (lat != 29) begin
            errors++;
            $display("FAIL midreset_next_latency: got %0d expected 29", lat);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_range();
        test_back_to_back();
        test_reset_mid_divide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
